serial_add_ctrl: RTL and testbench

Sequencing controller for the bit-serial adder datapath: two right-shift operand registers sharing one full adder and one carry flip-flop. It accepts a parallel operand pair through a ready/start handshake, loads the registers, and runs exactly WIDTH shift cycles LSB-first. It then presents the parallel sum, carry-out and signed overflow with a one-cycle done pulse. An accumulate mode reuses the previous sum as operand A, so a host can build running totals without re-supplying A.

---
 rtl/serial_add_ctrl_if.sv | 26 ++
 rtl/serial_add_ctrl.sv | 93 +++++++++
 tb/tb_serial_add_ctrl.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_add_ctrl_if.sv
// Handshake and operand/result bundle between a host and the bit-serial adder controller.
// The host drives start/acc/a/b; the controller returns status and the parallel result.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             acc;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             shift_en;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, acc, a, b,
    input  ready, shift_en, done, sum, cout, ovf
  );

  modport slave (
    input  start, acc, a, b,
    output ready, shift_en, done, sum, cout, ovf
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: loads an operand pair, shifts WIDTH bits LSB-first through one
// full adder, then reports sum, carry-out and signed overflow with a one-cycle done pulse.
module serial_add_ctrl #(
  parameter int WIDTH = 4,
  parameter int CW    = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_add_ctrl_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             cout_q;
  logic             ovf_q;
  logic [1:0]       fa;
  logic             last_bit;

  // Returns {carry_out, sum_bit}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    full_add = {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
  endfunction

  assign fa       = full_add(ra[0], rb[0], carry);
  assign last_bit = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = ADD;
      ADD:     if (last_bit)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Shift datapath; the carry into the MSB is still in 'carry' on the final shift edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      ra     <= '0;
      rb     <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (!bus.acc) ra <= bus.a;
            rb    <= bus.b;
            carry <= 1'b0;
            cnt   <= '0;
          end
        end
        ADD: begin
          ra    <= {fa[0], ra[WIDTH-1:1]};
          rb    <= {1'b0, rb[WIDTH-1:1]};
          carry <= fa[1];
          cnt   <= cnt + CW'(1);
          if (last_bit) begin
            cout_q <= fa[1];
            ovf_q  <= carry ^ fa[1];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ready    = (state_q == IDLE);
  assign bus.shift_en = (state_q == ADD);
  assign bus.done     = (state_q == DONE);
  assign bus.sum      = ra;
  assign bus.cout     = cout_q;
  assign bus.ovf      = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: directed and random additions against an
// arithmetic reference model of the sum, carry and signed overflow.
module tb_serial_add_ctrl;
  localparam int W  = 4;
  localparam int CW = 3;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  logic [W-1:0] m_sum;
  logic         m_cout;
  logic         m_ovf;

  serial_add_ctrl_if #(.WIDTH(W)) bus ();

  serial_add_ctrl #(.WIDTH(W), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_sum  = '0;
    m_cout = 1'b0;
    m_ovf  = 1'b0;
  endtask

  // One complete addition, entered and left just after a rising edge.
  task automatic do_add(input logic [W-1:0] a_in, input logic [W-1:0] b_in, input logic acc_in);
    logic [W-1:0] op_a;
    logic [W-1:0] exp_sum;
    logic [W:0]   full;
    logic         exp_cout;
    logic         exp_ovf;
    int           guard;
    guard = 0;
    while (bus.ready !== 1'b1 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    n_cmp++;
    if (bus.ready !== 1'b1) begin
      n_err++;
      $display("FAIL ready_wait: ready=%b required 1", bus.ready);
    end
    op_a     = acc_in ? m_sum : a_in;
    full     = {1'b0, op_a} + {1'b0, b_in};
    exp_sum  = full[W-1:0];
    exp_cout = full[W];
    exp_ovf  = (op_a[W-1] == b_in[W-1]) && (exp_sum[W-1] != op_a[W-1]);
    bus.start = 1'b1;
    bus.a     = a_in;
    bus.b     = b_in;
    bus.acc   = acc_in;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
    bus.acc   = 1'($urandom);
    for (int k = 1; k <= W; k++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.shift_en !== 1'b1 || bus.done !== 1'b0 || bus.ready !== 1'b0) begin
        n_err++;
        $display("FAIL add_phase cyc%0d: shift_en/done/ready=%b%b%b required 100",
                 k, bus.shift_en, bus.done, bus.ready);
      end
      if (k == 1) begin
        n_cmp++;
        if (bus.cout !== m_cout || bus.ovf !== m_ovf) begin
          n_err++;
          $display("FAIL flags_hold: cout/ovf=%b%b required %b%b", bus.cout, bus.ovf, m_cout, m_ovf);
        end
      end
    end
    @(negedge clk);
    n_cmp++;
    if (bus.done !== 1'b1 || bus.shift_en !== 1'b0 || bus.ready !== 1'b0) begin
      n_err++;
      $display("FAIL done_phase: done/shift_en/ready=%b%b%b required 100",
               bus.done, bus.shift_en, bus.ready);
    end
    n_cmp++;
    if (bus.sum !== exp_sum) begin
      n_err++;
      $display("FAIL sum %h+%h acc=%b: got %h required %h", op_a, b_in, acc_in, bus.sum, exp_sum);
    end
    n_cmp++;
    if (bus.cout !== exp_cout || bus.ovf !== exp_ovf) begin
      n_err++;
      $display("FAIL cout_ovf %h+%h: got %b%b required %b%b", op_a, b_in, bus.cout, bus.ovf,
               exp_cout, exp_ovf);
    end
    m_sum  = exp_sum;
    m_cout = exp_cout;
    m_ovf  = exp_ovf;
    @(negedge clk);
    n_cmp++;
    if (bus.done !== 1'b0 || bus.ready !== 1'b1 || bus.sum !== exp_sum) begin
      n_err++;
      $display("FAIL after_done: done/ready=%b%b sum=%h required 01 sum=%h",
               bus.done, bus.ready, bus.sum, exp_sum);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_cmp++;
    if (bus.ready !== 1'b1 || bus.done !== 1'b0 || bus.shift_en !== 1'b0 ||
        bus.sum !== '0 || bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: rdy=%b done=%b sh=%b sum=%h cout=%b ovf=%b required 1 0 0 0 0 0",
               bus.ready, bus.done, bus.shift_en, bus.sum, bus.cout, bus.ovf);
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_acc_after_reset();
    do_add(4'b1001, 4'b0101, 1'b1);
  endtask

  task automatic test_basic();
    do_add(4'b1010, 4'b0011, 1'b0);
    do_add(4'b1111, 4'b0001, 1'b0);
    do_add(4'b0111, 4'b0001, 1'b0);
  endtask

  task automatic test_accumulate();
    do_add(4'b1010, 4'b0011, 1'b0);
    do_add(4'b0101, 4'b0011, 1'b1);
    do_add(4'b0101, 4'b0010, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++)
      do_add(W'($urandom), W'($urandom), ($urandom_range(0, 2) == 0));
  endtask

  task automatic test_back_to_back();
    int n_done;
    int last_done;
    n_done    = 0;
    last_done = -1;
    bus.start = 1'b1;
    bus.acc   = 1'b0;
    bus.a     = 4'b0001;
    bus.b     = 4'b0001;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        n_done++;
        n_cmp++;
        if (bus.sum !== 4'b0010) begin
          n_err++;
          $display("FAIL b2b_sum cyc%0d: got %h required 2", cyc, bus.sum);
        end
        if (last_done >= 0) begin
          n_cmp++;
          if (cyc - last_done != W + 2) begin
            n_err++;
            $display("FAIL b2b_spacing: got %0d required %0d", cyc - last_done, W + 2);
          end
        end
        last_done = cyc;
      end
    end
    bus.start = 1'b0;
    n_cmp++;
    if (n_done != 5) begin
      n_err++;
      $display("FAIL b2b_count: got %0d done pulses required 5", n_done);
    end
    repeat (W + 3) @(posedge clk);
    #1;
    m_sum  = 4'b0010;
    m_cout = 1'b0;
    m_ovf  = 1'b0;
  endtask

  task automatic test_ignore_start();
    bus.start = 1'b1;
    bus.acc   = 1'b0;
    bus.a     = 4'b0011;
    bus.b     = 4'b0001;
    @(posedge clk); #1;
    bus.a = 4'b1111;
    bus.b = 4'b1111;
    for (int k = 1; k <= W + 1; k++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.done !== (k == W + 1)) begin
        n_err++;
        $display("FAIL ignore_done cyc%0d: got %b required %b", k, bus.done, (k == W + 1));
      end
    end
    n_cmp++;
    if (bus.sum !== 4'b0100) begin
      n_err++;
      $display("FAIL ignore_sum: got %h required 4", bus.sum);
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.ready !== 1'b1 || bus.done !== 1'b0 || bus.sum !== 4'b0100) begin
        n_err++;
        $display("FAIL ignore_idle cyc%0d: ready=%b done=%b sum=%h required 1 0 4",
                 k, bus.ready, bus.done, bus.sum);
      end
    end
    @(posedge clk); #1;
    m_sum  = 4'b0100;
    m_cout = 1'b0;
    m_ovf  = 1'b0;
  endtask

  task automatic test_mid_reset();
    do_add(4'b1000, 4'b1000, 1'b0);
    bus.start = 1'b1;
    bus.acc   = 1'b0;
    bus.a     = 4'b0101;
    bus.b     = 4'b0110;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++;
    if (bus.ready !== 1'b1 || bus.done !== 1'b0 || bus.shift_en !== 1'b0 ||
        bus.sum !== '0 || bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset: rdy=%b done=%b sh=%b sum=%h cout=%b ovf=%b required 1 0 0 0 0 0",
               bus.ready, bus.done, bus.shift_en, bus.sum, bus.cout, bus.ovf);
    end
    model_reset();
    do_add(4'b0100, 4'b0100, 1'b0);
  endtask

  task automatic test_rst_start();
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.acc   = 1'b0;
    bus.a     = 4'b0111;
    bus.b     = 4'b0111;
    @(posedge clk); #1;
    rst       = 1'b0;
    bus.start = 1'b0;
    model_reset();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.done !== 1'b0 || bus.ready !== 1'b1 || bus.sum !== '0) begin
        n_err++;
        $display("FAIL rst_start cyc%0d: done=%b ready=%b sum=%h required 0 1 0",
                 k, bus.done, bus.ready, bus.sum);
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.acc   = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    model_reset();
    @(posedge clk); #1;
    test_reset();
    test_acc_after_reset();
    test_basic();
    test_accumulate();
    test_random();
    test_back_to_back();
    test_ignore_start();
    test_mid_reset();
    test_rst_start();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
